// File: rtl/logic_gate_unit_seq.sv
// rtl/logic_gate_unit_seq.sv - registered WIDTH-bit gate unit with valid/ready stage and truth-table sweep
module logic_gate_unit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             sweep_done,
    output logic [15:0]      signature
);

    localparam int CW = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0]       sig_q, sig_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              out_valid_q, out_valid_d;
    // Marks whether the beat in the output register came from the sweep
    // engine; an external beat left over from IDLE must drain without
    // being folded into the signature or advancing the counter.
    logic              out_sweep_q, out_sweep_d;

    logic              free;
    logic              out_fire;
    logic              sweep_accept;
    logic              last_accept;
    logic [CW-1:0]     next_idx;

    function automatic logic [WIDTH-1:0] gate_f(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (f_op)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = ~x;
            3'd3:    r = ~y;
            3'd4:    r = ~(x & y);
            3'd5:    r = ~(x | y);
            3'd6:    r = x ^ y;
            default: r = ~(x ^ y);
        endcase
        return r;
    endfunction

    assign free         = !out_valid_q || out_ready;
    assign out_fire     = out_valid_q && out_ready;
    assign sweep_accept = (state_q == S_SWEEP) && out_fire && out_sweep_q;
    assign last_accept  = sweep_accept && (cnt_q == CNT_LAST);
    // Index of the beat to load this cycle: if the current sweep beat is
    // leaving, the next one goes in right behind it for full throughput.
    assign next_idx     = sweep_accept ? (cnt_q + CNT_ONE) : cnt_q;

    assign in_ready   = !rst && (state_q == S_IDLE) && free;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign busy       = (state_q != S_IDLE);
    assign sweep_done = (state_q == S_DONE);
    assign signature  = sig_q;

    // Next-state, output-stage and sweep bookkeeping.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        sig_d       = sig_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        out_sweep_d = out_sweep_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    result_d    = gate_f(op, a, b);
                    out_valid_d = 1'b1;
                    out_sweep_d = 1'b0;
                end
                if (start && mode) begin
                    state_d = S_SWEEP;
                    op_d    = op;
                    cnt_d   = '0;
                    sig_d   = '0;
                end
            end
            S_SWEEP: begin
                if (sweep_accept) begin
                    sig_d = {sig_q[14:0], sig_q[15]} ^ {{(16-WIDTH){1'b0}}, result_q};
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (last_accept) begin
                    state_d = S_DONE;
                end else if (free) begin
                    result_d    = gate_f(op_q, next_idx[CW-1:WIDTH], next_idx[WIDTH-1:0]);
                    out_valid_d = 1'b1;
                    out_sweep_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            sig_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            out_sweep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            sig_q       <= sig_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            out_sweep_q <= out_sweep_d;
        end
    end

endmodule
